cpu_trace_buffer: RTL and testbench

- Synthesizable, parametrised trace-capture unit attached to the CPU's retire-side signals: PC, Instruction, ALUResult and CarryOut.
- Records retired-instruction samples in a circular buffer, with pre-trigger history, a programmable trigger and a programmable post-trigger count.
- After capture, the buffer is drained oldest-first through a simple read port.
- Replaces free-running simulation monitoring with on-chip, trigger-qualified capture usable in silicon and in benches.

---
 rtl/cpu_trace_buffer.sv | 165 ++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: trigger-qualified capture of retired-instruction samples
// into a circular buffer, drained oldest-first through a registered read port.
// Each entry is {carry, alu_result, instr, pc}.
module cpu_trace_buffer #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int ENTRY_W = PC_W + INSTR_W + DATA_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               carry,
  input  logic               arm,
  input  logic               abort,
  input  logic [1:0]         trig_mode,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [INSTR_W-1:0] trig_instr,
  input  logic [AW-1:0]      post_count,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_valid,
  output logic [AW:0]        count,
  output logic [AW-1:0]      trig_pos,
  output logic               wrapped,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW-1:0] POS_MAX  = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW-1:0]        post_rem;
  logic [1:0]           mode_q;
  logic [PC_W-1:0]      trig_pc_q;
  logic [INSTR_W-1:0]   trig_instr_q;
  logic                 match;
  logic                 sample;
  logic                 wr_en;
  logic                 arm_take;
  logic                 pop;
  logic                 full;

  assign state    = state_q;
  assign full     = (count == CNT_FULL);
  assign sample   = valid && (state_q == ARMED || state_q == CAPTURE);
  // abort outranks everything; arm is only honoured from IDLE or DONE.
  assign wr_en    = !abort && sample;
  assign arm_take = !abort && arm && (state_q == IDLE || state_q == DONE);
  assign pop      = !abort && !arm && (state_q == DONE) && rd_en && (count != '0);

  // Trigger comparison against the configuration latched at arm.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    match = 1'b0;
    case (mode_q)
      2'd0:    match = 1'b1;
      2'd1:    match = (pc == trig_pc_q);
      2'd2:    match = (instr == trig_instr_q);
      default: match = carry;
    endcase
  end

  // Next-state logic for the capture sequence.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (arm) state_d = ARMED;
        ARMED:   if (sample && match) state_d = (post_rem != '0) ? CAPTURE : DONE;
        CAPTURE: if (sample && post_rem == PTR_ONE) state_d = DONE;
        DONE:    if (arm) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Sample storage.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; count and pointers define which entries are live.
    if (wr_en) mem[wr_ptr] <= {carry, alu_result, instr, pc};
  end

  // Pointers, occupancy, trigger bookkeeping and the registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      trig_pos     <= '0;
      wrapped      <= 1'b0;
      post_rem     <= '0;
      mode_q       <= '0;
      trig_pc_q    <= '0;
      trig_instr_q <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (abort) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        trig_pos <= '0;
        wrapped  <= 1'b0;
      end else if (arm_take) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        trig_pos     <= '0;
        wrapped      <= 1'b0;
        mode_q       <= trig_mode;
        trig_pc_q    <= trig_pc;
        trig_instr_q <= trig_instr;
        post_rem     <= post_count;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + PTR_ONE;
          if (full) begin
            // Oldest entry is overwritten: the read side follows it.
            rd_ptr  <= rd_ptr + PTR_ONE;
            wrapped <= 1'b1;
            if (state_q == CAPTURE && trig_pos != '0) trig_pos <= trig_pos - PTR_ONE;
          end else begin
            count <= count + CNT_ONE;
          end
          if (state_q == ARMED && match) trig_pos <= full ? POS_MAX : count[AW-1:0];
          if (state_q == CAPTURE) post_rem <= post_rem - PTR_ONE;
        end
        if (pop) begin
          rd_data  <= mem[rd_ptr];
          rd_valid <= 1'b1;
          rd_ptr   <= rd_ptr + PTR_ONE;
          count    <= count - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed scenarios plus randomized capture rounds,
// checked against a queue-based reference model; popped entries are matched
// by an independent monitor against a scoreboard queue.
module tb_cpu_trace_buffer;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 8;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int ENTRY_W = PC_W + INSTR_W + DATA_W + 1;

  localparam int S_IDLE    = 0;
  localparam int S_ARMED   = 1;
  localparam int S_CAPTURE = 2;
  localparam int S_DONE    = 3;

  typedef logic [ENTRY_W-1:0] entry_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               valid;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  alu_result;
  logic               carry;
  logic               arm;
  logic               abort;
  logic [1:0]         trig_mode;
  logic [PC_W-1:0]    trig_pc;
  logic [INSTR_W-1:0] trig_instr;
  logic [AW-1:0]      post_count;
  logic               rd_en;
  logic [ENTRY_W-1:0] rd_data;
  logic               rd_valid;
  logic [AW:0]        count;
  logic [AW-1:0]      trig_pos;
  logic               wrapped;
  logic [1:0]         state;

  cpu_trace_buffer #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .valid(valid), .pc(pc), .instr(instr),
    .alu_result(alu_result), .carry(carry), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_pc(trig_pc), .trig_instr(trig_instr),
    .post_count(post_count), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .count(count), .trig_pos(trig_pos),
    .wrapped(wrapped), .state(state)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the buffer is a plain queue of retained samples.
  entry_t       m_q[$];
  entry_t       exp_q[$];
  entry_t       popped[$];
  int           m_state, m_wrapped, m_trig_pos, m_rdv;
  int           m_mode, m_post, m_after, m_n, m_trig_abs, m_first_abs;
  logic [PC_W-1:0]    m_tpc;
  logic [INSTR_W-1:0] m_tinstr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state    = S_IDLE;
    m_q.delete();
    m_wrapped  = 0;
    m_trig_pos = 0;
    m_rdv      = 0;
  endtask

  // Applies the rules for the inputs currently driven, for the coming edge.
  task automatic model_update();
    bit hit;
    m_rdv = 0;
    if (abort) begin
      m_state = S_IDLE; m_q.delete(); m_wrapped = 0; m_trig_pos = 0;
    end else if (arm && (m_state == S_IDLE || m_state == S_DONE)) begin
      m_state = S_ARMED; m_q.delete(); m_wrapped = 0; m_trig_pos = 0;
      m_mode = int'(trig_mode); m_tpc = trig_pc; m_tinstr = trig_instr;
      m_post = int'(post_count); m_n = 0; m_first_abs = 0;
    end else if (valid && (m_state == S_ARMED || m_state == S_CAPTURE)) begin
      m_q.push_back({carry, alu_result, instr, pc});
      m_n++;
      if (m_q.size() > DEPTH) begin
        void'(m_q.pop_front());
        m_first_abs++;
        m_wrapped = 1;
      end
      if (m_state == S_ARMED) begin
        hit = 0;
        case (m_mode)
          0:       hit = 1;
          1:       hit = (pc == m_tpc);
          2:       hit = (instr == m_tinstr);
          default: hit = carry;
        endcase
        if (hit) begin
          m_trig_abs = m_n - 1;
          m_after    = 0;
          m_state    = (m_post == 0) ? S_DONE : S_CAPTURE;
        end
      end else begin
        m_after++;
        if (m_after == m_post) m_state = S_DONE;
      end
      if (m_state == S_DONE) m_trig_pos = m_trig_abs - m_first_abs;
    end else if (m_state == S_DONE && rd_en && m_q.size() > 0) begin
      exp_q.push_back(m_q.pop_front());
      m_rdv = 1;
    end
  endtask

  // One clock: update the model, take the edge, compare visible state.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("state", 32'(state), 32'(m_state));
    check("count", 32'(count), 32'(m_q.size()));
    check("wrapped", 32'(wrapped), 32'(m_wrapped));
    check("rd_valid", 32'(rd_valid), 32'(m_rdv));
    if (m_state != S_CAPTURE) check("trig_pos", 32'(trig_pos), 32'(m_trig_pos));
    if (rd_valid) popped.push_back(rd_data);
  endtask

  task automatic do_cycle(input logic v, input logic [PC_W-1:0] p, input logic [INSTR_W-1:0] i,
                          input logic [DATA_W-1:0] d, input logic c, input logic a,
                          input logic ab, input logic re);
    valid = v; pc = p; instr = i; alu_result = d; carry = c;
    arm = a; abort = ab; rd_en = re;
    step();
  endtask

  task automatic idle_cycle();
    do_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic arm_with(input logic [1:0] mode, input logic [PC_W-1:0] tpc,
                          input logic [INSTR_W-1:0] tinstr, input logic [AW-1:0] post);
    trig_mode = mode; trig_pc = tpc; trig_instr = tinstr; post_count = post;
    do_cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic sample_in(input int k, input logic c);
    do_cycle(1'b1, PC_W'(k), INSTR_W'($urandom), DATA_W'(k), c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int budget);
    popped.delete();
    for (int k = 0; k < budget && m_q.size() > 0; k++)
      do_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycle();
  endtask

  // Monitor: every presented read response must match the oldest outstanding expectation.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 32'(rd_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(e));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; valid = 0; pc = '0; instr = '0; alu_result = '0; carry = 0;
    arm = 0; abort = 0; trig_mode = '0; trig_pc = '0; trig_instr = '0;
    post_count = '0; rd_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'(S_IDLE));
    check("reset_count", 32'(count), 32'(0));
    check("reset_rd_data", 32'(rd_data), 32'(0));
    check("reset_rd_valid", 32'(rd_valid), 32'(0));
    reset = 1'b1;
    idle_cycle();

    // Immediate trigger, three post-trigger samples.
    arm_with(2'd0, '0, '0, 4'd3);
    for (int k = 0; k < 5; k++) sample_in(k, 1'b0);
    check("imm_state", 32'(state), 32'(S_DONE));
    check("imm_count", 32'(count), 32'(4));
    check("imm_trig_pos", 32'(trig_pos), 32'(0));
    drain(8);
    check("imm_pops", 32'(popped.size()), 32'(4));
    for (int k = 0; k < popped.size(); k++)
      check("imm_pop_pc", 32'(popped[k][PC_W-1:0]), 32'(k));

    // Empty read: nothing popped, count stays at zero.
    do_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("empty_rd_valid", 32'(rd_valid), 32'(0));
    check("empty_count", 32'(count), 32'(0));

    // PC match at 4'hA with two post samples.
    arm_with(2'd1, 4'hA, '0, 4'd2);
    for (int k = 0; k < 16; k++) sample_in(k, 1'b0);
    check("pcm_state", 32'(state), 32'(S_DONE));
    check("pcm_count", 32'(count), 32'(13));
    check("pcm_trig_pos", 32'(trig_pos), 32'(10));
    drain(20);
    check("pcm_first_pc", 32'(popped[0][PC_W-1:0]), 32'(0));
    check("pcm_last_pc", 32'(popped[popped.size()-1][PC_W-1:0]), 32'hC);

    // Wrap: carry trigger at index 30 after 30 non-triggering samples.
    arm_with(2'd3, '0, '0, 4'd3);
    for (int k = 0; k < 34; k++) sample_in(k, (k == 30));
    check("wrap_count", 32'(count), 32'(16));
    check("wrap_wrapped", 32'(wrapped), 32'(1));
    check("wrap_trig_pos", 32'(trig_pos), 32'(12));
    drain(20);
    check("wrap_pops", 32'(popped.size()), 32'(16));
    for (int k = 0; k < popped.size(); k++)
      check("wrap_pop_alu", 32'(popped[k][PC_W+INSTR_W +: DATA_W]), 32'(18 + k));

    // Valid gaps during capture.
    arm_with(2'd1, 4'hA, '0, 4'd2);
    for (int k = 0; k <= 10; k++) sample_in(k, 1'b0);
    idle_cycle();
    check("gap_state1", 32'(state), 32'(S_CAPTURE));
    sample_in(11, 1'b0);
    idle_cycle();
    check("gap_state2", 32'(state), 32'(S_CAPTURE));
    sample_in(12, 1'b0);
    check("gap_count", 32'(count), 32'(13));
    drain(20);
    check("gap_pop_b", 32'(popped[11][PC_W-1:0]), 32'hB);
    check("gap_pop_c", 32'(popped[12][PC_W-1:0]), 32'hC);

    // Reads and a second arm are ignored while ARMED; abort from ARMED.
    arm_with(2'd1, 4'hF, '0, 4'd1);
    for (int k = 0; k < 3; k++) sample_in(k, 1'b0);
    do_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("armed_rd_count", 32'(count), 32'(3));
    check("armed_rd_valid", 32'(rd_valid), 32'(0));
    arm_with(2'd0, '0, '0, 4'd0);
    check("armed_rearm_state", 32'(state), 32'(S_ARMED));
    check("armed_rearm_count", 32'(count), 32'(3));
    do_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort in CAPTURE, with arm in the same cycle.
    arm_with(2'd0, '0, '0, 4'd5);
    for (int k = 0; k < 3; k++) sample_in(k, 1'b0);
    check("abort_pre_state", 32'(state), 32'(S_CAPTURE));
    do_cycle(1'b1, 4'h7, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("abort_state", 32'(state), 32'(S_IDLE));
    check("abort_count", 32'(count), 32'(0));

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      arm_with(2'($urandom_range(0, 3)), PC_W'($urandom_range(0, 15)),
               INSTR_W'($urandom_range(0, 7)), AW'($urandom_range(0, 15)));
      for (int k = 0; k < 80 && (m_state == S_ARMED || m_state == S_CAPTURE); k++)
        do_cycle(($urandom_range(0, 9) < 7), PC_W'($urandom), INSTR_W'($urandom_range(0, 7)),
                 DATA_W'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 149) == 0), 1'($urandom));
      for (int k = 0; k < 60 && m_state == S_DONE && m_q.size() > 0; k++)
        do_cycle(1'($urandom), PC_W'($urandom), '0, '0, 1'b0, 1'b0, 1'b0,
                 ($urandom_range(0, 9) < 7));
      idle_cycle();
    end

    // Asynchronous reset between edges in the middle of readout.
    arm_with(2'd0, '0, '0, 4'd5);
    for (int k = 0; k < 6; k++) sample_in(k, 1'b0);
    do_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'(S_IDLE));
    check("arst_count", 32'(count), 32'(0));
    check("arst_rd_data", 32'(rd_data), 32'(0));
    check("arst_rd_valid", 32'(rd_valid), 32'(0));
    check("arst_trig_pos", 32'(trig_pos), 32'(0));
    check("arst_wrapped", 32'(wrapped), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    check("arst_hold_rd_valid", 32'(rd_valid), 32'(0));
    rd_en = 0;
    reset = 1'b1;
    arm_with(2'd0, '0, '0, 4'd1);
    sample_in(9, 1'b0);
    sample_in(10, 1'b0);
    check("arst_restart_count", 32'(count), 32'(2));
    drain(6);
    check("arst_restart_pc", 32'(popped[0][PC_W-1:0]), 32'(9));

    repeat (2) idle_cycle();
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
